zbt_bitstream_fifo: RTL

Parametrised byte-in / bit-out elementary-stream FIFO that spills through a configurable region of the external ZBT SRAM. Bytes from the system-stream demultiplexer are packed big-endian into 32-bit words, queued in an on-chip input stage, written into a circular ZBT region on alternating access slots, and read back into an on-chip output stage. The output stage feeds a 64-bit bit window with variable 1..MAX_SHIFT-bit consumption for the VLD/header parsers. Serves audio and video channels by instantiation with different region parameters.

---
 rtl/zbt_bitstream_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/zbt_bitstream_fifo.sv
// Byte-in / bit-out elementary-stream FIFO that spills through a circular region of the ZBT SRAM.
// Bytes pack big-endian into words, stage on chip, round-trip through ZBT, then feed a 64-bit bit window.
module zbt_bitstream_fifo #(
  parameter int ZBT_ADDR_W = 19,
  parameter int REGION_BITS = 17,
  parameter logic [ZBT_ADDR_W-REGION_BITS-1:0] REGION_BASE = '1,
  parameter int ZBT_RD_LAT = 4,
  parameter int STAGE_AW = 4,
  parameter int MAX_SHIFT = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic                   byte_ready_o,
  input  logic                   eos_i,
  input  logic                   shift_en_i,
  input  logic [5:0]             shift_amt_i,
  output logic [31:0]            data_o,
  output logic                   data_valid_o,
  output logic                   byte_align_o,
  output logic [REGION_BITS:0]   level_o,
  input  logic                   zbt_access_i,
  output logic [ZBT_ADDR_W-1:0]  zbt_addr_o,
  output logic [31:0]            zbt_wdata_o,
  output logic                   zbt_we_o,
  input  logic [31:0]            zbt_rdata_i
);

  localparam int STAGE_DEPTH = 1 << STAGE_AW;
  localparam logic [REGION_BITS:0] REGION_WORDS = {1'b1, {REGION_BITS{1'b0}}};

  logic                   slot;
  logic [1:0]             pack_cnt;
  logic [31:0]            pack_word;
  logic [31:0]            in_mem [STAGE_DEPTH];
  logic [STAGE_AW-1:0]    in_wptr, in_rptr;
  logic [STAGE_AW:0]      in_count;
  logic [31:0]            out_mem [STAGE_DEPTH];
  logic [STAGE_AW-1:0]    out_wptr, out_rptr;
  logic [STAGE_AW:0]      out_count;
  logic [REGION_BITS-1:0] wr_ptr, rd_ptr;
  logic [REGION_BITS:0]   level;
  logic [ZBT_RD_LAT-1:0]  rd_vld;
  logic [STAGE_AW:0]      inflight;
  logic [63:0]            window;
  logic [6:0]             win_count;
  logic [2:0]             consumed;

  logic                   byte_accept;
  logic [31:0]            packed_word;
  logic [2:0]             packed_cnt;
  logic                   commit;
  logic                   in_push;
  logic                   read_issue;
  logic                   rd_arrive;
  logic [STAGE_AW+1:0]    out_occupancy;
  logic                   shift_ok;
  logic [6:0]             amt;
  logic [6:0]             remain;
  logic                   refill;
  logic [63:0]            win_next;
  logic [6:0]             cnt_next;

  assign byte_ready_o  = in_count < (STAGE_AW+1)'(STAGE_DEPTH - 1);
  assign byte_accept   = byte_valid_i & byte_ready_o;
  assign in_push       = commit & (in_count != (STAGE_AW+1)'(STAGE_DEPTH));
  assign rd_arrive     = rd_vld[ZBT_RD_LAT-1];
  assign out_occupancy = {1'b0, out_count} + {1'b0, inflight};

  assign zbt_we_o    = slot & zbt_access_i & ~flush_i & (in_count != '0) & (level != REGION_WORDS);
  assign read_issue  = ~slot & zbt_access_i & ~flush_i & (level != '0)
                       & (out_occupancy < (STAGE_AW+2)'(STAGE_DEPTH));
  assign zbt_addr_o  = {REGION_BASE, slot ? wr_ptr : rd_ptr};
  assign zbt_wdata_o = (in_count != '0) ? in_mem[in_rptr] : 32'h0;

  assign data_o       = window[63:32];
  assign data_valid_o = win_count >= 7'd32;
  assign byte_align_o = consumed == 3'd0;
  assign level_o      = level;

  // The byte is placed first so a simultaneous eos_i commits it along with the partial word.
  always_comb begin
    packed_word = pack_word;
    packed_cnt  = {1'b0, pack_cnt};
    if (byte_accept) begin
      packed_word[{~pack_cnt, 3'b000} +: 8] = byte_data_i;
      packed_cnt = packed_cnt + 3'd1;
    end
    commit = packed_cnt[2] | (eos_i & (packed_cnt != 3'd0));
  end

  // Illegal shift requests are ignored; the refilled word lands directly below the surviving bits.
  always_comb begin
    shift_ok = shift_en_i & data_valid_o & (shift_amt_i != 6'd0)
               & ({1'b0, shift_amt_i} <= 7'(MAX_SHIFT));
    amt      = shift_ok ? {1'b0, shift_amt_i} : 7'd0;
    remain   = win_count - amt;
    refill   = (remain <= 7'd32) & (out_count != '0);
    win_next = window << amt;
    cnt_next = remain;
    if (refill) begin
      win_next = win_next | ({out_mem[out_rptr], 32'h0} >> remain);
      cnt_next = remain + 7'd32;
    end
  end

  always_ff @(posedge clock) begin
    if (in_push) in_mem[in_wptr] <= packed_word;
    if (rd_arrive) out_mem[out_wptr] <= zbt_rdata_i;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slot      <= 1'b0;
      pack_cnt  <= '0;
      pack_word <= '0;
      in_wptr   <= '0;
      in_rptr   <= '0;
      in_count  <= '0;
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_vld    <= '0;
      inflight  <= '0;
      window    <= '0;
      win_count <= '0;
      consumed  <= '0;
    end else begin
      slot <= ~slot;
      if (flush_i) begin
        pack_cnt  <= '0;
        pack_word <= '0;
        in_wptr   <= '0;
        in_rptr   <= '0;
        in_count  <= '0;
        out_wptr  <= '0;
        out_rptr  <= '0;
        out_count <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        rd_vld    <= '0;
        inflight  <= '0;
        window    <= '0;
        win_count <= '0;
        consumed  <= '0;
      end else begin
        pack_cnt  <= commit ? 2'd0 : packed_cnt[1:0];
        pack_word <= commit ? 32'h0 : packed_word;
        if (in_push) in_wptr <= in_wptr + 1'b1;
        if (zbt_we_o) begin
          in_rptr <= in_rptr + 1'b1;
          wr_ptr  <= wr_ptr + 1'b1;
        end
        in_count <= in_count + (STAGE_AW+1)'(in_push) - (STAGE_AW+1)'(zbt_we_o);
        if (read_issue) rd_ptr <= rd_ptr + 1'b1;
        level    <= level + (REGION_BITS+1)'(zbt_we_o) - (REGION_BITS+1)'(read_issue);
        rd_vld   <= (rd_vld << 1) | ZBT_RD_LAT'(read_issue);
        inflight <= inflight + (STAGE_AW+1)'(read_issue) - (STAGE_AW+1)'(rd_arrive);
        if (rd_arrive) out_wptr <= out_wptr + 1'b1;
        if (refill) out_rptr <= out_rptr + 1'b1;
        out_count <= out_count + (STAGE_AW+1)'(rd_arrive) - (STAGE_AW+1)'(refill);
        window    <= win_next;
        win_count <= cnt_next;
        consumed  <= consumed + amt[2:0];
      end
    end
  end

endmodule
